fsm_rd_buffer: RTL and testbench
================================

FSM_RD_BUFFER -- requirements
Module: fsm_rd_buffer

Interface
REQ-001 Parameter DW, default 8, data word width.
REQ-002 Parameter DEPTH, default 4, buffer entries; power of two, minimum 2.
REQ-003 Parameter LW, default 8, burst-length counter width.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 rd  input  1  read strobe from the go/ds/rd controller; din is valid on each cycle rd=1.
REQ-007 ds  input  1  done strobe from the same controller; ends the current burst.
REQ-008 din  input  DW  read data.
REQ-009 dout  output  DW  head-of-buffer word.
REQ-010 dout_valid  output  1  dout holds a valid word (buffer not empty).
REQ-011 dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1.
REQ-012 burst_done  output  1  one-cycle pulse when a burst closes.
REQ-013 burst_len  output  LW  words accepted in the last closed burst; held until the next close.
REQ-014 level  output  clog2(DEPTH+1)  current buffer occupancy.
REQ-015 overflow  output  1  sticky flag: at least one word was dropped.

Function
REQ-016 States: IDLE, CAPT, DRAIN, encoded in a 2-bit register.
REQ-017 IDLE: rd=1 SHALL move to CAPT, push din, and set the burst counter to 1 (0 if dropped); ds=1 while in IDLE SHALL be ignored.
REQ-018 CAPT: each rd=1 cycle SHALL push din; rd=0 and ds=0 SHALL hold CAPT (controller delay cycles).
REQ-019 CAPT with ds=1 SHALL go to DRAIN next cycle, pulse burst_done for exactly that cycle, and load burst_len with the counter, including any push made in the same cycle.
REQ-020 DRAIN: level=0 SHALL return to IDLE; rd=1 in DRAIN SHALL drop din and set overflow.
REQ-021 A push SHALL be accepted when level<DEPTH, or when level=DEPTH and a pop occurs in the same cycle; otherwise din is dropped and overflow is set.
REQ-022 A pop occurs when dout_valid=1 and dout_ready=1, in any state; pops SHALL proceed during CAPT (streaming).
REQ-023 A simultaneous push and pop SHALL leave level unchanged; otherwise level moves by ±1.
REQ-024 dout SHALL be the oldest stored word (FIFO order); dout_valid = (level!=0), combinational from registered state.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-026 The burst counter SHALL count accepted pushes only and saturate at 2^LW-1.
REQ-027 Overflow SHALL clear only on reset.
REQ-028 Latency: a word pushed at edge N SHALL have dout_valid=1 after edge N when the buffer was empty.

Reset
REQ-029 While rst=0: state=IDLE, pointers=0, level=0, dout_valid=0, burst_done=0, burst_len=0, overflow=0, counter=0; dout = storage content, don't-care.
REQ-030 Reset asserted mid-burst SHALL discard all buffered words with no burst_done pulse.
REQ-031 The first push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-032 State encodings and the default DW/DEPTH/LW values SHALL live in a shared package, fsm_pkg, also usable by the controller.
REQ-033 Storage and pointers SHALL be one sub-module, sync_fifo (push, pop, din, dout, level, full, empty); fsm_rd_buffer holds the FSM, the burst counter and the flags.

Verification
REQ-034 Reset, then rd=1 for 3 cycles with din=0xA1, 0xA2, 0xA3, then ds=1, dout_ready=1 -> burst_done single pulse, burst_len=3, dout order A1, A2, A3, then IDLE with level=0.
REQ-035 dout_ready=0, rd=1 for 6 cycles with DEPTH=4 -> level=4, overflow=1, burst_len=4 after ds.
REQ-036 Buffer full, then rd=1 and dout_ready=1 in the same cycle -> push accepted, level stays 4, overflow stays 0.
REQ-037 Reset asserted after 2 words of a burst -> level=0, dout_valid=0, no burst_done; the next burst reports its own length.
REQ-038 ds=1 while in IDLE -> no state change and no pulse; rd=1 during DRAIN -> word dropped, overflow=1.
REQ-039 Drive go/rd/ds from the controller pattern 1,1,0,1,1,0,1,0,1,1 -> burst_len equals the number of rd cycles, and all words are drained in order.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared definitions for the read-buffer FSM and its go/ds/rd controller:
// state encodings and default widths.
package fsm_pkg;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 4;
    localparam int LW_DEF    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CAPT  = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small FIFO with asynchronous head read so dout is valid right after the
// first push. The caller never pushes when full without a pop, nor pops when empty.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DW-1:0]                din,
    output logic [DW-1:0]                dout,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LVW = $clog2(DEPTH+1);

    logic [DW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [LVW-1:0] level_q;

    // Storage is not reset; its content is don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;
    assign full  = (level_q == LVW'(DEPTH));
    assign empty = (level_q == '0);

endmodule

// File: rtl/fsm_rd_buffer.sv
// Captures read bursts into a FIFO, reports each burst's length on close,
// and flags any dropped word with a sticky overflow bit.
module fsm_rd_buffer
    import fsm_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int LW    = LW_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd,
    input  logic                         ds,
    input  logic [DW-1:0]                din,
    output logic [DW-1:0]                dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic                         burst_done,
    output logic [LW-1:0]                burst_len,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);

    state_e          state_q, state_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   burst_len_q, burst_len_d;
    logic            burst_done_q, burst_done_d;
    logic            overflow_q, overflow_d;
    logic            push, pop, full, empty;

    // A pop frees a slot in the same cycle, so a full buffer can still accept.
    assign pop  = !empty && dout_ready;
    assign push = rd && (state_q != ST_DRAIN) && (!full || pop);

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (rd)    state_d = ST_CAPT;
            ST_CAPT:  if (ds)    state_d = ST_DRAIN;
            ST_DRAIN: if (empty) state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        burst_len_d  = burst_len_q;
        burst_done_d = 1'b0;
        overflow_d   = overflow_q | (rd && !push);
        case (state_q)
            ST_IDLE: begin
                if (rd) begin
                    cnt_d    = '0;
                    cnt_d[0] = push;
                end
            end
            ST_CAPT: begin
                if (push && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // The closing length includes a push made in the ds cycle.
                if (ds) begin
                    burst_done_d = 1'b1;
                    burst_len_d  = cnt_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            burst_len_q  <= '0;
            burst_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            burst_len_q  <= burst_len_d;
            burst_done_q <= burst_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign dout_valid = !empty;
    assign burst_done = burst_done_q;
    assign burst_len  = burst_len_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fsm_rd_buffer.sv
// Directed and random stimulus for fsm_rd_buffer, checked every cycle against
// a queue-based reference model of the burst buffer.
module tb_fsm_rd_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 8;
    localparam int LVW   = $clog2(DEPTH+1);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           rd = 1'b0;
    logic           ds = 1'b0;
    logic           dout_ready = 1'b0;
    logic [DW-1:0]  din = '0;
    logic [DW-1:0]  dout;
    logic           dout_valid;
    logic           burst_done;
    logic [LW-1:0]  burst_len;
    logic [LVW-1:0] level;
    logic           overflow;

    fsm_rd_buffer #(.DW(DW), .DEPTH(DEPTH), .LW(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd         (rd),
        .ds         (ds),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .burst_done (burst_done),
        .burst_len  (burst_len),
        .level      (level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: stored words, burst open/draining flags, counters.
    byte unsigned q[$];
    bit  m_open, m_drain, m_done, m_ovf;
    int  m_cnt, m_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("level", 32'(level), q.size());
        check("valid", 32'(dout_valid), 32'(q.size() != 0));
        if (q.size() != 0) check("dout", 32'(dout), 32'(q[0]));
        check("done", 32'(burst_done), 32'(m_done));
        check("len", 32'(burst_len), m_len);
        check("ovf", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic model_reset();
        q.delete();
        m_open = 0; m_drain = 0; m_done = 0; m_ovf = 0;
        m_cnt = 0; m_len = 0;
    endtask

    task automatic model_step(input bit r, input bit d, input bit rdy, input byte unsigned w);
        int n;
        bit pop, idle, acc;
        n    = q.size();
        pop  = (n > 0) && rdy;
        idle = !m_open && !m_drain;
        acc  = r && !m_drain && ((n < DEPTH) || pop);
        if (r && !acc) m_ovf = 1;
        m_done = 0;
        if (idle && r) begin
            m_cnt  = acc ? 1 : 0;
            m_open = 1;
        end else if (m_open) begin
            if (acc && m_cnt < (2**LW - 1)) m_cnt++;
            if (d) begin
                m_len = m_cnt; m_done = 1; m_open = 0; m_drain = 1;
            end
        end else if (m_drain && n == 0) begin
            m_drain = 0;
        end
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(w);
    endtask

    task automatic cycle(input bit r, input bit d, input bit rdy, input byte unsigned w);
        @(negedge clk);
        rst = 1'b1;
        rd = r; ds = d; dout_ready = rdy; din = w;
        model_step(r, d, rdy, w);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Reset is asserted between clock edges to exercise its asynchronous path.
    task automatic do_reset();
        @(negedge clk);
        rd = 0; ds = 0; dout_ready = 0;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q.size() != 0 || m_drain || m_open); i++) begin
            cycle(0, m_open, 1, 8'h00);
        end
        check("drained_level", 32'(level), 0);
    endtask

    initial begin
        logic [9:0] pattern;
        do_reset();

        // Three-word burst, then close and drain in order.
        cycle(1, 0, 0, 8'hA1);
        cycle(1, 0, 0, 8'hA2);
        cycle(1, 0, 0, 8'hA3);
        cycle(0, 1, 1, 8'h00);
        check("r034_len", 32'(burst_len), 3);
        check("r034_pulse", 32'(burst_done), 1);
        drain();

        // Overfill a stalled buffer.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 8'($urandom));
        cycle(0, 1, 0, 8'h00);
        check("r035_level", 32'(level), 4);
        check("r035_ovf", 32'(overflow), 1);
        check("r035_len", 32'(burst_len), 4);
        drain();

        // Full buffer with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'($urandom));
        cycle(1, 0, 1, 8'h5C);
        check("r036_level", 32'(level), 4);
        check("r036_ovf", 32'(overflow), 0);
        cycle(0, 1, 1, 8'h00);
        drain();

        // Reset in the middle of a burst.
        cycle(1, 0, 0, 8'h11);
        cycle(1, 0, 0, 8'h12);
        do_reset();
        check("r037_valid", 32'(dout_valid), 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 1'($urandom), 8'($urandom));
        cycle(0, 1, 0, 8'h00);
        check("r037_len", 32'(burst_len), 3);
        drain();

        // ds ignored in IDLE; rd dropped in DRAIN.
        cycle(0, 1, 0, 8'h00);
        cycle(0, 1, 1, 8'h00);
        check("r038_idle_done", 32'(burst_done), 0);
        cycle(1, 0, 0, 8'h77);
        cycle(0, 1, 0, 8'h00);
        cycle(1, 0, 0, 8'h78);
        check("r038_ovf", 32'(overflow), 1);
        check("r038_level", 32'(level), 1);
        drain();

        // Controller pattern with gaps.
        do_reset();
        pattern = 10'b1101101011;
        for (int i = 9; i >= 0; i--) cycle(pattern[i], 0, 1, 8'($urandom));
        cycle(0, 1, 1, 8'h00);
        check("r039_len", 32'(burst_len), 7);
        drain();

        // Long streaming burst saturates the counter.
        do_reset();
        for (int i = 0; i < 300; i++) cycle(1, 0, 1, 8'($urandom));
        cycle(0, 1, 1, 8'h00);
        check("sat_len", 32'(burst_len), 255);
        drain();

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), ($urandom % 8) == 0, 1'($urandom), 8'($urandom));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
